// File: rtl/kas_control_unit_mc.sv
// Multicycle control unit for the K&S datapath.
// Moore-style FSM with a req/ack RAM handshake (bounded wait), conditional
// and overflow branches, single-step hold, resume-from-halt and a counter
// of retired instructions.

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_HALT,
        I_BNZERO,
        I_BNNEG,
        I_BOV,
        I_BNOV
    } decoded_instruction_type;
endpackage

module kas_control_unit_mc
    import k_and_s_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 16,
    parameter bit ENABLE_OVF_BR = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    input  logic                    mem_ack,
    input  logic                    step_mode,
    input  logic                    step_go,
    input  logic                    resume,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    mem_req,
    output logic                    halt,
    output logic                    bus_error,
    output logic [CNT_W-1:0]        instr_count
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ALU,
        S_MOVE,
        S_BRANCH,
        S_NEXT,
        S_STEP_HOLD,
        S_HALT,
        S_ERROR
    } state_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

    state_t          state, state_n;
    logic [1:0]      op_q, op_n;
    logic [TW-1:0]   tcnt;
    logic            mem_state;
    logic            tmo;
    logic            unused_flags;

    // The unsigned carry flag is not a branch condition in this ISA.
    assign unused_flags = unsigned_overflow;

    assign mem_state = (state == S_FETCH) || (state == S_LOAD) || (state == S_STORE);
    // An ack on the final allowed cycle still completes the access.
    assign tmo = (MEM_TIMEOUT > 0) && mem_state && (tcnt == TMAX) && !mem_ack;

    // State, latched ALU op, wait counter and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            op_q        <= 2'b00;
            tcnt        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_n;
            op_q  <= op_n;
            // Any state change restarts the wait count, so each memory
            // state begins at zero; staying in one means no ack yet.
            if (state_n != state)
                tcnt <= '0;
            else if (mem_state)
                tcnt <= tcnt + TW'(1);
            if (state == S_BRANCH || state == S_NEXT)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next-state logic and ALU op latching in DECODE.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        case (state)
            S_FETCH: begin
                if (mem_ack)  state_n = S_DECODE;
                else if (tmo) state_n = S_ERROR;
            end
            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:   state_n = S_LOAD;
                    I_STORE:  state_n = S_STORE;
                    I_OR:     begin op_n = 2'b00; state_n = S_ALU; end
                    I_ADD:    begin op_n = 2'b01; state_n = S_ALU; end
                    I_SUB:    begin op_n = 2'b10; state_n = S_ALU; end
                    I_AND:    begin op_n = 2'b11; state_n = S_ALU; end
                    I_MOVE:   state_n = S_MOVE;
                    I_BRANCH: state_n = S_BRANCH;
                    I_HALT:   state_n = S_HALT;
                    I_BZERO:  state_n = zero_op  ? S_BRANCH : S_NEXT;
                    I_BNZERO: state_n = !zero_op ? S_BRANCH : S_NEXT;
                    I_BNEG:   state_n = neg_op   ? S_BRANCH : S_NEXT;
                    I_BNNEG:  state_n = !neg_op  ? S_BRANCH : S_NEXT;
                    I_BOV:    state_n = (ENABLE_OVF_BR && signed_overflow)  ? S_BRANCH : S_NEXT;
                    I_BNOV:   state_n = (ENABLE_OVF_BR && !signed_overflow) ? S_BRANCH : S_NEXT;
                    default:  state_n = S_NEXT;
                endcase
            end
            S_LOAD, S_STORE: begin
                if (mem_ack)  state_n = S_NEXT;
                else if (tmo) state_n = S_ERROR;
            end
            S_ALU, S_MOVE: state_n = S_NEXT;
            S_BRANCH, S_NEXT: state_n = step_mode ? S_STEP_HOLD : S_FETCH;
            S_STEP_HOLD: begin
                if (step_go || !step_mode) state_n = S_FETCH;
            end
            S_HALT: begin
                if (resume) state_n = S_NEXT;
            end
            S_ERROR: state_n = S_ERROR;
            default: state_n = S_ERROR;
        endcase
    end

    // Moore outputs from state; RAM-completion enables also qualified by ack.
    // Everything is forced low while rst is high so mem_req drops at once.
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        mem_req          = 1'b0;
        halt             = 1'b0;
        bus_error        = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ir_enable = mem_ack;
                end
                S_LOAD: begin
                    mem_req          = 1'b1;
                    addr_sel         = 1'b1;
                    write_reg_enable = mem_ack;
                end
                S_STORE: begin
                    mem_req          = 1'b1;
                    addr_sel         = 1'b1;
                    ram_write_enable = 1'b1;
                end
                S_ALU: begin
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    flags_reg_enable = 1'b1;
                    operation        = op_q;
                end
                S_MOVE: begin
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                end
                S_BRANCH: begin
                    branch    = 1'b1;
                    pc_enable = 1'b1;
                    addr_sel  = 1'b1;
                end
                S_NEXT: pc_enable = 1'b1;
                S_HALT: halt = 1'b1;
                S_ERROR: begin
                    halt      = 1'b1;
                    bus_error = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
